// File: rtl/dcc_bit_decoder_pkg.sv
// Shared definitions for the DCC bit decoder.
//   dcc_state_e : decoder FSM states (HUNT, LOW, HIGH)
//   dcc_cls_e   : half-period classes (CLS_NONE, CLS_ONE, CLS_ZERO)
//   DEF_*       : default timing windows in clk cycles. They bracket the
//                 encoder prescaler, which emits 8-clk halves for a 1 and
//                 16-clk halves for a 0.
//   classify()  : maps a half-period length onto a class.
package dcc_bit_decoder_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } dcc_state_e;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_ONE  = 2'd1,
        CLS_ZERO = 2'd2
    } dcc_cls_e;

    localparam int unsigned DEF_CNT_W    = 8;
    localparam int unsigned DEF_ONE_MIN  = 6;
    localparam int unsigned DEF_ONE_MAX  = 11;
    localparam int unsigned DEF_ZERO_MIN = 13;
    localparam int unsigned DEF_ZERO_MAX = 20;
    localparam int unsigned DEF_PRE_MIN  = 10;

    function automatic dcc_cls_e classify(input int unsigned cnt,
                                          input int unsigned one_min,
                                          input int unsigned one_max,
                                          input int unsigned zero_min,
                                          input int unsigned zero_max);
        if (cnt >= one_min && cnt <= one_max) return CLS_ONE;
        if (cnt >= zero_min && cnt <= zero_max) return CLS_ZERO;
        return CLS_NONE;
    endfunction

endpackage

// File: rtl/dcc_bit_decoder_if.sv
// Decoded bit stream from the DCC bit decoder to the packet assembler.
//   bit_valid    : 1-cycle pulse, a bit has been decoded
//   bit_value    : decoded bit, meaningful only while bit_valid is high
//   bit_error    : 1-cycle pulse, framing error or timeout
//   preamble_ok  : level, run of consecutive 1s has reached the preamble length
//   packet_start : 1-cycle pulse with bit_valid when a 0 follows a preamble
// master = decoder side, slave = assembler side.
interface dcc_bit_decoder_if;

    logic bit_valid;
    logic bit_value;
    logic bit_error;
    logic preamble_ok;
    logic packet_start;

    modport master (
        output bit_valid, bit_value, bit_error, preamble_ok, packet_start
    );

    modport slave (
        input bit_valid, bit_value, bit_error, preamble_ok, packet_start
    );

endinterface

// File: rtl/dcc_sync_edge.sv
// Two-flop synchronizer with registered edge pulses.
//   clk, reset_n : clock and asynchronous active-low reset
//   din          : asynchronous input
//   rise, fall   : 1-cycle pulses, registered, for a synchronized 0->1 / 1->0
// RESET_LEVEL is the idle level of the line; every stage resets to it so that
// releasing reset on an idle line never produces a pulse.
module dcc_sync_edge #(
    parameter bit RESET_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic prev;

    // NOTE: every flop here uses <= so all stages sample the values from
    // before the clock edge; blocking assignments would collapse the chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= RESET_LEVEL;
            sync2 <= RESET_LEVEL;
            prev  <= RESET_LEVEL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
            rise  <= sync2 & ~prev;
            fall  <= ~sync2 & prev;
        end
    end

endmodule

// File: rtl/dcc_bit_decoder.sv
// DCC bit decoder: recovers bits from a DCC waveform by timing half-periods.
//   clk, reset_n : clock and asynchronous active-low reset
//   dcc_in       : DCC waveform, asynchronous to clk, idles high
//   bus          : decoded bit stream (bit_valid, bit_value, bit_error,
//                  preamble_ok, packet_start), all registered
// A bit is a low half followed by a high half of the same class. An event
// caused by a dcc_in edge appears three clk edges after the edge that first
// samples the new level.
module dcc_bit_decoder
    import dcc_bit_decoder_pkg::*;
#(
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned ONE_MIN  = DEF_ONE_MIN,
    parameter int unsigned ONE_MAX  = DEF_ONE_MAX,
    parameter int unsigned ZERO_MIN = DEF_ZERO_MIN,
    parameter int unsigned ZERO_MAX = DEF_ZERO_MAX,
    parameter int unsigned PRE_MIN  = DEF_PRE_MIN
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               dcc_in,
    dcc_bit_decoder_if.master  bus
);

    if (!(ONE_MIN <= ONE_MAX && ONE_MAX < ZERO_MIN && ZERO_MIN <= ZERO_MAX &&
          ZERO_MAX < (2 ** CNT_W) - 1)) begin : g_bad_timing
        $error("dcc_bit_decoder: timing windows must satisfy ONE_MIN <= ONE_MAX < ZERO_MIN <= ZERO_MAX < 2**CNT_W-1");
    end

    localparam int unsigned RUN_W = $clog2(PRE_MIN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(ZERO_MAX + 1);
    localparam logic [RUN_W-1:0] PRE_RUN = RUN_W'(PRE_MIN);

    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    dcc_cls_e         cls;
    dcc_cls_e         stored_cls;
    dcc_state_e       state;
    logic [RUN_W-1:0] ones_run;

    logic bit_valid_q;
    logic bit_value_q;
    logic bit_error_q;
    logic preamble_q;
    logic packet_start_q;

    dcc_sync_edge #(.RESET_LEVEL(1'b1)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (dcc_in),
        .rise    (rise),
        .fall    (fall)
    );

    // cnt holds the number of cycles since the last edge pulse; on an edge
    // pulse cycle it is the length of the half that just ended.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (rise || fall) begin
            cnt <= CNT_W'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign cls = classify(32'(cnt), ONE_MIN, ONE_MAX, ZERO_MIN, ZERO_MAX);

    // Edges alternate after synchronization, so LOW only waits for a rise and
    // HIGH only for a fall. An edge wins over the timeout on the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= HUNT;
            stored_cls     <= CLS_NONE;
            ones_run       <= '0;
            bit_valid_q    <= 1'b0;
            bit_value_q    <= 1'b0;
            bit_error_q    <= 1'b0;
            preamble_q     <= 1'b0;
            packet_start_q <= 1'b0;
        end else begin
            bit_valid_q    <= 1'b0;
            bit_error_q    <= 1'b0;
            packet_start_q <= 1'b0;
            case (state)
                HUNT: begin
                    if (fall) state <= LOW;
                end
                LOW: begin
                    if (rise) begin
                        if (cls != CLS_NONE) begin
                            stored_cls <= cls;
                            state      <= HIGH;
                        end else begin
                            bit_error_q <= 1'b1;
                            ones_run    <= '0;
                            preamble_q  <= 1'b0;
                            state       <= HUNT;
                        end
                    end else if (cnt == TIMEOUT) begin
                        bit_error_q <= 1'b1;
                        ones_run    <= '0;
                        preamble_q  <= 1'b0;
                        state       <= HUNT;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        // This falling edge also opens the low half of the next bit.
                        state <= LOW;
                        if (cls == stored_cls) begin
                            bit_valid_q <= 1'b1;
                            bit_value_q <= (cls == CLS_ONE);
                            if (cls == CLS_ONE) begin
                                if (ones_run != PRE_RUN) begin
                                    ones_run   <= ones_run + 1'b1;
                                    preamble_q <= (ones_run == PRE_RUN - 1'b1);
                                end
                            end else begin
                                packet_start_q <= preamble_q;
                                ones_run       <= '0;
                                preamble_q     <= 1'b0;
                            end
                        end else begin
                            bit_error_q <= 1'b1;
                            ones_run    <= '0;
                            preamble_q  <= 1'b0;
                        end
                    end else if (cnt == TIMEOUT) begin
                        bit_error_q <= 1'b1;
                        ones_run    <= '0;
                        preamble_q  <= 1'b0;
                        state       <= HUNT;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

    assign bus.bit_valid    = bit_valid_q;
    assign bus.bit_value    = bit_value_q;
    assign bus.bit_error    = bit_error_q;
    assign bus.preamble_ok  = preamble_q;
    assign bus.packet_start = packet_start_q;

endmodule

// File: tb/tb_dcc_bit_decoder.sv
// Self-checking bench for dcc_bit_decoder.
// The bench drives dcc_in on falling clk edges. An edge model computes, from
// half-period lengths alone, the cycle at which each output event must be
// seen, and a compare process checks all outputs on every falling edge.
// Per-scenario tallies are also checked against hand-computed literals.
module tb_dcc_bit_decoder;

    localparam int LAT    = 4;       // drive cycle -> sampled output cycle
    localparam int TO     = 21;      // timeout length after the last edge
    localparam int TO_LAT = LAT + TO;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic dcc_in  = 1'b1;

    dcc_bit_decoder_if bus ();

    dcc_bit_decoder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .dcc_in  (dcc_in),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- edge-level model ----------------
    bit exp_valid[int];
    bit exp_value[int];
    bit exp_err[int];
    bit exp_ps[int];
    bit exp_pre[int];
    bit exp_pre_lvl = 1'b0;

    int m_phase  = 0;   // 0 idle, 1 inside a low half, 2 inside a high half
    int m_stored = 0;   // class of the low half: 1 = one, 0 = zero
    int m_last   = 0;
    int m_ones   = 0;
    bit m_line   = 1'b1;
    int jcnt     = 0;

    function automatic int cls_of(input int n);
        if (n >= 6 && n <= 11) return 1;
        if (n >= 13 && n <= 20) return 0;
        return -1;
    endfunction

    task automatic model_err(input int at);
        exp_err[at] = 1'b1;
        exp_pre[at] = 1'b0;
        m_ones = 0;
    endtask

    task automatic model_edge(input int k, input bit lvl);
        int gap;
        int c;
        gap = k - m_last;
        if (m_phase != 0) begin
            if (gap > TO) begin
                // the tentative timeout already fired
                m_phase = 0;
                m_ones  = 0;
            end else begin
                exp_err.delete(m_last + TO_LAT);
                exp_pre.delete(m_last + TO_LAT);
            end
        end
        c = cls_of(gap);
        case (m_phase)
            0: if (!lvl) m_phase = 1;
            1: begin
                if (c < 0) begin
                    model_err(k + LAT);
                    m_phase = 0;
                end else begin
                    m_stored = c;
                    m_phase  = 2;
                end
            end
            default: begin
                m_phase = 1;
                if (c == m_stored) begin
                    exp_valid[k + LAT] = 1'b1;
                    exp_value[k + LAT] = (c == 1);
                    if (c == 1) begin
                        if (m_ones < 10) m_ones++;
                        exp_pre[k + LAT] = (m_ones == 10);
                    end else begin
                        if (m_ones == 10) exp_ps[k + LAT] = 1'b1;
                        m_ones = 0;
                        exp_pre[k + LAT] = 1'b0;
                    end
                end else begin
                    model_err(k + LAT);
                end
            end
        endcase
        m_last = k;
        if (m_phase != 0) begin
            exp_err[k + TO_LAT] = 1'b1;
            exp_pre[k + TO_LAT] = 1'b0;
        end
    endtask

    task automatic model_reset();
        exp_valid.delete();
        exp_value.delete();
        exp_err.delete();
        exp_ps.delete();
        exp_pre.delete();
        exp_pre_lvl = 1'b0;
        m_phase = 0;
        m_ones  = 0;
        m_line  = 1'b1;
        m_last  = cyc;
    endtask

    // ---------------- compare process and tallies ----------------
    int  n_valid  = 0;
    int  n_err    = 0;
    int  n_ps     = 0;
    int  pre_at   = 0;
    int  last_err = 0;
    logic [15:0] bits = '0;
    bit  ev;

    always @(negedge clk) begin
        if (reset_n) begin
            if (exp_pre.exists(cyc)) exp_pre_lvl = exp_pre[cyc];
            ev = exp_valid.exists(cyc);
            check("bit_valid", 32'(bus.bit_valid), 32'(ev));
            if (ev) check("bit_value", 32'(bus.bit_value), 32'(exp_value[cyc]));
            check("bit_error", 32'(bus.bit_error), 32'(exp_err.exists(cyc)));
            check("packet_start", 32'(bus.packet_start), 32'(exp_ps.exists(cyc)));
            check("preamble_ok", 32'(bus.preamble_ok), 32'(exp_pre_lvl));
            if (bus.bit_valid) begin
                n_valid++;
                bits = {bits[14:0], bus.bit_value};
                if (bus.preamble_ok && pre_at == 0) pre_at = n_valid;
            end
            if (bus.bit_error) begin
                n_err++;
                last_err = cyc;
            end
            if (bus.packet_start) n_ps++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_line(input bit lvl);
        if (lvl != m_line) model_edge(cyc, lvl);
        m_line = lvl;
        dcc_in = lvl;
    endtask

    function automatic int jit();
        jcnt++;
        return (jcnt % 3) - 1;
    endfunction

    task automatic half(input bit lvl, input int n);
        set_line(lvl);
        hold(n);
    endtask

    task automatic send_bit(input bit b);
        int n;
        n = b ? 8 : 16;
        half(1'b0, n + jit());
        half(1'b1, n + jit());
    endtask

    // closing falling edge; the last bit is reported 4 cycles later
    task automatic finish_bits();
        half(1'b0, 8);
        #2;
    endtask

    // let the pending timeout expire, then return the line to idle high
    task automatic settle();
        hold(30);
        half(1'b1, 6);
    endtask

    task automatic clear_stats();
        #1;
        n_valid = 0;
        n_err   = 0;
        n_ps    = 0;
        pre_at  = 0;
        bits    = '0;
    endtask

    int k_rise;

    initial begin
        // reset state
        #2;
        check("reset bit_valid", 32'(bus.bit_valid), 32'd0);
        check("reset bit_error", 32'(bus.bit_error), 32'd0);
        check("reset preamble_ok", 32'(bus.preamble_ok), 32'd0);
        check("reset packet_start", 32'(bus.packet_start), 32'd0);
        hold(3);
        model_reset();
        reset_n = 1'b1;
        hold(5);

        // 1: bits 1,0,1
        clear_stats();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        finish_bits();
        check("s1 valid count", 32'(n_valid), 32'd3);
        check("s1 bits", 32'(bits[2:0]), 32'b101);
        check("s1 errors", 32'(n_err), 32'd0);
        settle();

        // 2: 12 ones then a 0
        clear_stats();
        repeat (12) send_bit(1'b1);
        send_bit(1'b0);
        finish_bits();
        check("s2 valid count", 32'(n_valid), 32'd13);
        check("s2 bits", 32'(bits[12:0]), 32'b1111111111110);
        check("s2 preamble at bit", 32'(pre_at), 32'd10);
        check("s2 packet_start count", 32'(n_ps), 32'd1);
        check("s2 preamble after 0", 32'(bus.preamble_ok), 32'd0);
        check("s2 errors", 32'(n_err), 32'd0);
        settle();

        // 3: low one-half, high zero-half, then a clean 1
        clear_stats();
        half(1'b0, 8 + jit());
        half(1'b1, 16 + jit());
        half(1'b0, 8 + jit());
        half(1'b1, 8 + jit());
        finish_bits();
        check("s3 errors", 32'(n_err), 32'd1);
        check("s3 valid count", 32'(n_valid), 32'd1);
        check("s3 bit", 32'(bits[0]), 32'd1);
        settle();

        // 4: nine 1s, low halves of 5 and 12, then one clean 1
        clear_stats();
        repeat (9) send_bit(1'b1);
        half(1'b0, 5);
        half(1'b1, 8);
        half(1'b0, 12);
        half(1'b1, 8);
        send_bit(1'b1);
        finish_bits();
        check("s4 errors", 32'(n_err), 32'd2);
        check("s4 valid count", 32'(n_valid), 32'd10);
        check("s4 preamble never set", 32'(pre_at), 32'd0);
        check("s4 preamble level", 32'(bus.preamble_ok), 32'd0);
        settle();

        // 5: line held high for 40 clk in HIGH
        clear_stats();
        half(1'b0, 8 + jit());
        set_line(1'b1);
        k_rise = cyc;
        hold(40);
        half(1'b0, 8 + jit());
        half(1'b1, 8 + jit());
        finish_bits();
        check("s5 errors", 32'(n_err), 32'd1);
        // 3-edge pipeline (drive -> sample is 4 cycles) plus 21 cycles
        check("s5 timeout delay", 32'(last_err - k_rise), 32'd25);
        check("s5 valid count", 32'(n_valid), 32'd1);
        check("s5 bit", 32'(bits[0]), 32'd1);
        settle();

        // 6: reset in the low half of a 0 while preamble_ok is set
        repeat (10) send_bit(1'b1);
        set_line(1'b0);
        hold(7);
        #2;
        check("s6 preamble before reset", 32'(bus.preamble_ok), 32'd1);
        reset_n = 1'b0;
        #1;
        check("s6 async preamble_ok", 32'(bus.preamble_ok), 32'd0);
        check("s6 async bit_valid", 32'(bus.bit_valid), 32'd0);
        check("s6 async bit_error", 32'(bus.bit_error), 32'd0);
        dcc_in = 1'b1;
        model_reset();
        hold(3);
        reset_n = 1'b1;
        hold(5);
        clear_stats();
        send_bit(1'b1);
        send_bit(1'b0);
        finish_bits();
        check("s6 valid count", 32'(n_valid), 32'd2);
        check("s6 bits", 32'(bits[1:0]), 32'b10);
        check("s6 errors", 32'(n_err), 32'd0);
        check("s6 packet_start count", 32'(n_ps), 32'd0);
        settle();

        hold(40);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
